// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous single-port memory between fetch (P0) and LSU (P1).
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed priority with P1 highest.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 64
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  P0_REQ,
    input  logic [ADDR_WIDTH-1:0] P0_ADDR,
    output logic                  P0_GNT,
    input  logic                  P1_REQ,
    input  logic                  P1_WE,
    input  logic [ADDR_WIDTH-1:0] P1_ADDR,
    input  logic [DATA_WIDTH-1:0] P1_WDATA,
    output logic                  P1_GNT,
    output logic                  RSP_VALID,
    output logic                  RSP_PORT,
    output logic [DATA_WIDTH-1:0] RSP_RDATA,
    output logic                  RSP_ERR,
    output logic                  ERR_STICKY,
    output logic                  MEM_CS,
    output logic                  MEM_RE,
    output logic [ADDR_WIDTH-1:0] MEM_ADDR,
    output logic [DATA_WIDTH-1:0] MEM_WDATA,
    input  logic [DATA_WIDTH-1:0] MEM_RDATA
);

    typedef enum logic {
        PORT_P0 = 1'b0,
        PORT_P1 = 1'b1
    } port_e;

    localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);

    logic p0_gnt;
    logic p1_gnt;

`ifdef MEM_ARB_RR_EN
    // The pointer only moves on contested cycles, so a lone requester never steals a turn.
    port_e pref_port;
    logic  contested;

    assign contested = RST_N && P0_REQ && P1_REQ;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            pref_port <= PORT_P0;
        end else if (contested) begin
            pref_port <= (pref_port == PORT_P0) ? PORT_P1 : PORT_P0;
        end
    end

    always_comb begin
        p0_gnt = 1'b0;
        p1_gnt = 1'b0;
        if (RST_N) begin
            if (P0_REQ && P1_REQ) begin
                p0_gnt = (pref_port == PORT_P0);
                p1_gnt = (pref_port == PORT_P1);
            end else begin
                p0_gnt = P0_REQ;
                p1_gnt = P1_REQ;
            end
        end
    end
`else
    always_comb begin
        p0_gnt = 1'b0;
        p1_gnt = 1'b0;
        if (RST_N) begin
            p1_gnt = P1_REQ;
            p0_gnt = P0_REQ && !P1_REQ;
        end
    end
`endif

    logic                  any_gnt;
    port_e                 gnt_port;
    logic [ADDR_WIDTH-1:0] gnt_addr;
    logic                  gnt_write;
    logic                  gnt_in_range;

    always_comb begin
        any_gnt      = p0_gnt || p1_gnt;
        gnt_port     = p1_gnt ? PORT_P1 : PORT_P0;
        gnt_addr     = p1_gnt ? P1_ADDR : P0_ADDR;
        gnt_write    = p1_gnt && P1_WE;
        gnt_in_range = (gnt_addr < DEPTH_A);
    end

    logic                  mem_cs_q;
    logic                  mem_re_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;
    logic                  iss_rd_q;
    port_e                 iss_port_q;
    logic                  iss_err_q;
    logic                  err_sticky_q;

    // Issue stage: out-of-range accesses never reach the memory but still carry a read tag.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            mem_cs_q     <= 1'b0;
            mem_re_q     <= 1'b1;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            iss_rd_q     <= 1'b0;
            iss_port_q   <= PORT_P0;
            iss_err_q    <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            mem_cs_q    <= 1'b0;
            mem_re_q    <= 1'b1;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            iss_rd_q    <= any_gnt && !gnt_write;
            iss_port_q  <= gnt_port;
            iss_err_q   <= any_gnt && !gnt_in_range;
            if (any_gnt && gnt_in_range) begin
                mem_cs_q    <= 1'b1;
                mem_re_q    <= !gnt_write;
                mem_addr_q  <= gnt_addr;
                mem_wdata_q <= gnt_write ? P1_WDATA : '0;
            end
            if (any_gnt && !gnt_in_range) begin
                err_sticky_q <= 1'b1;
            end
        end
    end

    logic  rsp_valid_q;
    port_e rsp_port_q;
    logic  rsp_err_q;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            rsp_valid_q <= 1'b0;
            rsp_port_q  <= PORT_P0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= iss_rd_q;
            rsp_port_q  <= iss_rd_q ? iss_port_q : PORT_P0;
            rsp_err_q   <= iss_rd_q && iss_err_q;
        end
    end

    // The memory registers its own read data, so it is steered straight through here.
    assign RSP_RDATA  = (rsp_valid_q && !rsp_err_q) ? MEM_RDATA : '0;
    assign RSP_VALID  = rsp_valid_q;
    assign RSP_PORT   = rsp_port_q;
    assign RSP_ERR    = rsp_err_q;
    assign ERR_STICKY = err_sticky_q;
    assign MEM_CS     = mem_cs_q;
    assign MEM_RE     = mem_re_q;
    assign MEM_ADDR   = mem_addr_q;
    assign MEM_WDATA  = mem_wdata_q;
    assign P0_GNT     = p0_gnt;
    assign P1_GNT     = p1_gnt;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random traffic against a transaction-level model of mem_arbiter.
// Follows MEM_ARB_RR_EN the same way as the design when it is defined.
module tb_mem_arbiter;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        P0_REQ = 1'b0;
    logic [31:0] P0_ADDR = '0;
    logic        P0_GNT;
    logic        P1_REQ = 1'b0;
    logic        P1_WE = 1'b0;
    logic [31:0] P1_ADDR = '0;
    logic [31:0] P1_WDATA = '0;
    logic        P1_GNT;
    logic        RSP_VALID;
    logic        RSP_PORT;
    logic [31:0] RSP_RDATA;
    logic        RSP_ERR;
    logic        ERR_STICKY;
    logic        MEM_CS;
    logic        MEM_RE;
    logic [31:0] MEM_ADDR;
    logic [31:0] MEM_WDATA;
    logic [31:0] MEM_RDATA;

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(64)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .P0_REQ(P0_REQ), .P0_ADDR(P0_ADDR), .P0_GNT(P0_GNT),
        .P1_REQ(P1_REQ), .P1_WE(P1_WE), .P1_ADDR(P1_ADDR), .P1_WDATA(P1_WDATA), .P1_GNT(P1_GNT),
        .RSP_VALID(RSP_VALID), .RSP_PORT(RSP_PORT), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
        .ERR_STICKY(ERR_STICKY),
        .MEM_CS(MEM_CS), .MEM_RE(MEM_RE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
        .MEM_RDATA(MEM_RDATA)
    );

    always #5 CLK = ~CLK;

    // Synchronous single-port memory with registered read data.
    logic [31:0] mem [64];
    always @(posedge CLK) begin
        if (MEM_CS) begin
            if (!MEM_RE) mem[MEM_ADDR[5:0]] <= MEM_WDATA;
            else         MEM_RDATA <= mem[MEM_ADDR[5:0]];
        end
    end

    typedef struct {
        int          due;
        logic        port;
        logic        err;
        logic [31:0] data;
    } rsp_t;

    rsp_t        rsp_q[$];
    logic [31:0] ref_mem [64];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic        pref = 1'b0;
    logic        exp_cs = 1'b0;
    logic        exp_strict = 1'b1;
    logic        exp_re = 1'b1;
    logic [31:0] exp_addr = '0;
    logic [31:0] exp_wdata = '0;
    logic        exp_sticky = 1'b0;
    logic        eg0;
    logic        eg1;

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s cycle %0d: observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    // Compares everything visible this cycle, then advances the model past the coming edge.
    task automatic checkOutput();
        rsp_t        e;
        logic [31:0] a;
        logic        wr;
        eg0 = 1'b0;
        eg1 = 1'b0;
        if (RST_N) begin
            if (P0_REQ && P1_REQ) begin
`ifdef MEM_ARB_RR_EN
                eg0 = (pref == 1'b0);
                eg1 = (pref == 1'b1);
`else
                eg1 = 1'b1;
`endif
            end else begin
                eg0 = P0_REQ;
                eg1 = P1_REQ;
            end
        end
        checkValue("P0_GNT", {31'b0, P0_GNT}, {31'b0, eg0});
        checkValue("P1_GNT", {31'b0, P1_GNT}, {31'b0, eg1});
        checkValue("MEM_CS", {31'b0, MEM_CS}, {31'b0, exp_cs});
        if (exp_strict) begin
            checkValue("MEM_RE", {31'b0, MEM_RE}, {31'b0, exp_re});
            checkValue("MEM_ADDR", MEM_ADDR, exp_addr);
            checkValue("MEM_WDATA", MEM_WDATA, exp_wdata);
        end
        checkValue("ERR_STICKY", {31'b0, ERR_STICKY}, {31'b0, exp_sticky});
        if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
            e = rsp_q.pop_front();
            checkValue("RSP_VALID", {31'b0, RSP_VALID}, 32'd1);
            checkValue("RSP_PORT", {31'b0, RSP_PORT}, {31'b0, e.port});
            checkValue("RSP_ERR", {31'b0, RSP_ERR}, {31'b0, e.err});
            checkValue("RSP_RDATA", RSP_RDATA, e.data);
        end else begin
            checkValue("RSP_VALID idle", {31'b0, RSP_VALID}, 32'd0);
        end

        if (!RST_N) begin
            rsp_q.delete();
            pref       = 1'b0;
            exp_cs     = 1'b0;
            exp_strict = 1'b1;
            exp_re     = 1'b1;
            exp_addr   = '0;
            exp_wdata  = '0;
            exp_sticky = 1'b0;
        end else begin
`ifdef MEM_ARB_RR_EN
            if (P0_REQ && P1_REQ) pref = ~pref;
`endif
            exp_cs     = 1'b0;
            exp_strict = 1'b1;
            exp_re     = 1'b1;
            exp_addr   = '0;
            exp_wdata  = '0;
            if (eg0 || eg1) begin
                a  = eg1 ? P1_ADDR : P0_ADDR;
                wr = eg1 && P1_WE;
                if (a < 64) begin
                    exp_cs    = 1'b1;
                    exp_re    = !wr;
                    exp_addr  = a;
                    exp_wdata = wr ? P1_WDATA : 32'd0;
                    if (wr) ref_mem[a[5:0]] = P1_WDATA;
                end else begin
                    exp_strict = 1'b0;
                    exp_sticky = 1'b1;
                end
                if (!wr) rsp_q.push_back('{due: cyc + 2, port: eg1, err: (a >= 64),
                                           data: (a < 64) ? ref_mem[a[5:0]] : 32'd0});
            end
        end
    endtask

    task automatic applyStimulus(input logic rst_n, input logic p0r, input logic [31:0] p0a,
                                 input logic p1r, input logic p1w, input logic [31:0] p1a,
                                 input logic [31:0] p1d);
        RST_N    = rst_n;
        P0_REQ   = p0r;
        P0_ADDR  = p0a;
        P1_REQ   = p1r;
        P1_WE    = p1w;
        P1_ADDR  = p1a;
        P1_WDATA = p1d;
        @(negedge CLK);
        checkOutput();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    logic        p0_pend;
    logic [31:0] p0_a;
    logic        p1_pend;
    logic        p1_we;
    logic [31:0] p1_a;
    logic [31:0] p1_d;

    initial begin
        $display("[TB] start");
        // Power-up edge: registers are unknown until the first reset edge.
        RST_N  = 1'b0;
        P0_REQ = 1'b1;
        @(posedge CLK);
        #1;

        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 32'd3, 1'b0, 1'b0, 32'd0, 32'd0);

        for (int i = 0; i < 64; i++) applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, i, $urandom);
        idle(2);

        $display("[TB] write then read");
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 32'd5, 32'hDEADBEEF);
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd5, 32'd0);
        idle(3);

        $display("[TB] back-to-back fetch");
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, i, 32'h10 + i);
        idle(1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, i, 1'b0, 1'b0, 32'd0, 32'd0);
        idle(3);

        $display("[TB] contention");
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 32'd10, 1'b1, 1'b0, 32'd20, 32'd0);
        idle(3);

        $display("[TB] out of range");
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd64, 32'd0);
        idle(4);

        $display("[TB] reset mid-read");
        applyStimulus(1'b1, 1'b1, 32'd7, 1'b0, 1'b0, 32'd0, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        idle(3);

        $display("[TB] random traffic");
        p0_pend = 1'b0;
        p1_pend = 1'b0;
        p0_a = '0; p1_a = '0; p1_we = 1'b0; p1_d = '0;
        for (int n = 0; n < 3000; n++) begin
            if (!p0_pend && $urandom_range(0, 3) != 0) begin
                p0_pend = 1'b1;
                p0_a = ($urandom_range(0, 19) == 0) ? 32'd64 + $urandom_range(0, 100) : $urandom_range(0, 63);
            end
            if (!p1_pend && $urandom_range(0, 3) != 0) begin
                p1_pend = 1'b1;
                p1_we   = $urandom_range(0, 1) != 0;
                p1_d    = $urandom;
                p1_a = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFC0 | $urandom_range(0, 63) : $urandom_range(0, 63);
            end
            applyStimulus(($urandom_range(0, 199) != 0), p0_pend, p0_a, p1_pend, p1_we, p1_a, p1_d);
            if (eg0) p0_pend = 1'b0;
            if (eg1) p1_pend = 1'b0;
        end
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer that shares one synchronous single-port data memory between the instruction-fetch port (P0, read-only) and the load/store port (P1, read/write). Each cycle it grants at most one request and drives the memory's chip-select, read-enable, address and write-data from registers. It returns read data to the originating port with a fixed two-cycle latency. It sits between the core's fetch/LSU stages and the memory instance.

## Interface
- ADDR_WIDTH, 32, word address width
- DATA_WIDTH, 32, data word width
- DEPTH, 64, number of memory words; valid addresses 0..DEPTH-1
- CLK  in  1  clock, all state updates on rising edge
- RST_N  in  1  synchronous, active-low reset
- P0_REQ  in  1  fetch read request; held until granted
- P0_ADDR  in  ADDR_WIDTH  fetch word address
- P0_GNT  out  1  fetch request accepted this cycle
- P1_REQ  in  1  LSU request; held until granted
- P1_WE  in  1  1 = write, 0 = read
- P1_ADDR  in  ADDR_WIDTH  LSU word address
- P1_WDATA  in  DATA_WIDTH  LSU write data
- P1_GNT  out  1  LSU request accepted this cycle
- RSP_VALID  out  1  read response valid
- RSP_PORT  out  1  0 = P0, 1 = P1
- RSP_RDATA  out  DATA_WIDTH  read data
- RSP_ERR  out  1  read address was out of range
- ERR_STICKY  out  1  set by any out-of-range access; cleared only by reset
- MEM_CS  out  1  memory chip select
- MEM_RE  out  1  1 = read, 0 = write (qualified by MEM_CS)
- MEM_ADDR  out  ADDR_WIDTH  memory address
- MEM_WDATA  out  DATA_WIDTH  memory write data
- MEM_RDATA  in  DATA_WIDTH  memory read data, registered by the memory

## Operation
- Arbitration is combinational, in cycle N:
  - P0_GNT and P1_GNT are one-hot or zero.
  - Both are 0 while RST_N=0.
- Fixed priority (default): P1 wins when both ports request.
- Issue stage, registered at the end of cycle N, drives cycle N+1:
  - An in-range grant sets MEM_CS=1, MEM_ADDR=address, MEM_RE=!(P1 & P1_WE), MEM_WDATA=P1_WDATA for a write, otherwise 0.
  - An out-of-range grant (addr >= DEPTH) sets MEM_CS=0 and ERR_STICKY=1.
  - No grant: MEM_CS=0, MEM_RE=1, MEM_ADDR=0, MEM_WDATA=0.
- Response stage, registered at the end of cycle N+1, drives cycle N+2:
  - Reads only: RSP_VALID=1 and RSP_PORT=granted port.
  - In range: RSP_RDATA=MEM_RDATA and RSP_ERR=0. MEM_RDATA is passed through in cycle N+2.
  - Out of range: RSP_RDATA=0 and RSP_ERR=1.
- Writes produce no response; the grant is completion.
- Reset values: all outputs 0 except MEM_RE=1. The pipeline is cleared and the priority pointer is set to P0.

## Timing
- Grant is same-cycle as the request.
- Throughput is one access per cycle.
- Read latency is exactly 2 cycles from grant to RSP_VALID. Responses return in grant order, one per cycle, with no back-pressure: requesters must accept RSP_VALID unconditionally.
- Write granted in N is written to memory at the end of N+1.
- Write-then-read to the same address:
  - A write granted in N and a read of that address granted in N+1 returns the new data.
  - No forwarding is needed.
- Requests that are not granted are not latched. The requester must hold REQ, ADDR, WE and WDATA stable until GNT.
- Reset mid-operation: in-flight reads are discarded. RSP_VALID=0 and MEM_CS=0 in the cycle after the reset edge. No response is ever produced for pre-reset grants.
- Simultaneous out-of-range read and in-range traffic is handled per access. The error response occupies its normal N+2 slot.

## Configuration
- MEM_ARB_RR_EN defined:
  - Round-robin arbitration. A 1-bit pointer names the preferred port and resets to P0.
  - On a contested cycle (both REQ=1) the preferred port wins, and the pointer flips to the other port.
  - Uncontested grants do not move the pointer.
- MEM_ARB_RR_EN undefined: fixed priority with P1 highest. No pointer register.

## Test plan
- Reset: hold RST_N=0 for 3 cycles with P0_REQ=1.
  - Expect P0_GNT=0, MEM_CS=0, MEM_RE=1, RSP_VALID=0 and ERR_STICKY=0 throughout.
- Write then read:
  - P1 write addr 5 data 0xDEADBEEF in cycle 0, then P1 read addr 5 in cycle 1.
  - Expect MEM_CS=1, MEM_RE=0 in cycle 1.
  - Expect RSP_VALID=1, RSP_PORT=1, RSP_RDATA=0xDEADBEEF in cycle 3.
- Back-to-back fetch: P0 reads addrs 0,1,2 granted in cycles 0,1,2 (preloaded 0x10,0x11,0x12).
  - Expect RSP_VALID in cycles 2,3,4 with data 0x10,0x11,0x12 and RSP_PORT=0.
- Contention: P0 and P1 both request reads for 4 cycles.
  - Default build: P1_GNT=1 every cycle and P0_GNT=0.
  - With MEM_ARB_RR_EN: grants go P0,P1,P0,P1.
- Out of range: P1 read addr 64 with DEPTH=64.
  - Expect MEM_CS=0 in cycle N+1.
  - Expect RSP_VALID=1, RSP_ERR=1, RSP_RDATA=0 in N+2.
  - Expect ERR_STICKY=1 from N+1 until reset.
- Reset mid-read: grant a P0 read in cycle 0, then RST_N=0 in cycle 1.
  - Expect no RSP_VALID in cycles 2-3.
